inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the program counter and fetches one 32-bit instruction per commit over a req/ack instruction-memory handshake.
- Holds the instruction stable for the decoder.
- Computes the next PC from the decoder's jump select (M1) and branch-taken select (M5), which are fed back from the decoded instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; bits [1:0] must be 0.
- ADDR_W, 32, PC/instruction address width; fixed at 32 for this core.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold current instruction; blocks commit
- m1_i  in  1  decoder M1; 0 = jump, 1 = sequential/branch path
- m5_i  in  1  decoder M5; 1 = branch taken (beq & zero)
- imem_req_o  out  1  instruction memory read request
- imem_addr_o  out  32  fetch address (= pc_o)
- imem_rdata_i  in  32  instruction data, valid when imem_ack_i=1
- imem_ack_i  in  1  memory completes the read this cycle
- inst_o  out  32  held instruction to decoder
- inst_valid_o  out  1  inst_o is valid for the current pc_o
- pc_o  out  32  PC of the held/fetching instruction
- pc_plus4_o  out  32  pc_o + 4, combinational

Behaviour:
- Reset (asynchronous on rst_n low, any state):
  - pc_o=RESET_PC, inst_o=32'h0 (nop), inst_valid_o=0, imem_req_o=0, state=IDLE.
  - An in-flight fetch is abandoned; an ack arriving in IDLE is ignored.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: imem_req_o=1, imem_addr_o=pc_o. On imem_ack_i=1: inst_o<=imem_rdata_i, inst_valid_o<=1, go to EXEC. Otherwise stay in FETCH with no timeout; the request stays asserted with a stable address.
  - EXEC: imem_req_o=0; inst_o and pc_o are held.
    - If stall_i=0 (commit): pc_o<=next_pc, inst_valid_o<=0, go to FETCH.
    - If stall_i=1: hold everything.
    - imem_ack_i in EXEC is ignored.
- next_pc, priority order:
  - m1_i=0 (jump): {pc_plus4[31:28], inst_o[25:0], 2'b00}.
  - else m5_i=1 (branch taken): pc_plus4 + ({{14{inst_o[15]}}, inst_o[15:0], 2'b00}), modulo 2^32.
  - else: pc_plus4.
  - If m1_i=0 and m5_i=1 together, the jump wins.
- Minimum latency: 2 cycles per instruction (FETCH with same-cycle ack, then EXEC).
- pc_plus4 wraps 32'hFFFF_FFFC to 0.
- m1_i, m5_i and stall_i are sampled only in EXEC.
- pc_o[1:0] is always 0.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_inst_cnt_o[31:0] and perf_redirect_cnt_o[31:0], both reset to 0.
  - perf_inst_cnt_o increments on every commit.
  - perf_redirect_cnt_o increments on commits with a jump or taken branch.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mips_if_pkg:
  - fetch state enum (IDLE/FETCH/EXEC).
  - RESET_PC default.
  - Instruction field bit positions: imm16 [15:0], jidx [25:0], PC-region [31:28].
- Sub-module if_next_pc: purely combinational; inputs pc_plus4, inst, m1, m5; output next_pc.

Test Plan:
- Reset then ack with 0 wait states, rdata=32'h3401_0005, m1=1, m5=0, stall=0 -> imem_addr 3000 then 3004; inst_valid high 1 cycle per instruction.
- Fetch at 3000 with ack delayed 3 cycles -> imem_req stays 1 and addr stays 3000 for 4 cycles; inst_o updates only on the ack cycle.
- inst=32'h1000_FFFF (beq, offset -1), m5=1, pc=3004 -> next pc_o=3004.
- inst=32'h0800_0C10, m1=0, m5=1, pc=3008 -> next pc_o=3040 (jump priority).
- stall_i=1 for 5 cycles in EXEC -> pc_o/inst_o constant, imem_req=0; commit on the first stall_i=0 cycle.
- rst_n low during FETCH with ack pending -> outputs take reset values immediately, ack ignored; refetch from RESET_PC. With IF_PERF_CNT_EN: 3 commits including 1 jump -> inst_cnt=3, redirect_cnt=1.

Source files
------------

// File: rtl/mips_if_pkg.sv
// Shared definitions for the instruction-fetch slice.
//  - fetch_state_e : fetch FSM states (IDLE / FETCH / EXEC)
//  - RESET_PC_DEFAULT : default program counter after reset
//  - instruction field bit positions (imm16, jump index, PC region)
//  - branch_offset() : sign-extended, word-scaled branch displacement
package mips_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int unsigned IMM16_LSB  = 0;
  localparam int unsigned IMM16_MSB  = 15;
  localparam int unsigned JIDX_LSB   = 0;
  localparam int unsigned JIDX_MSB   = 25;
  localparam int unsigned REGION_LSB = 28;
  localparam int unsigned REGION_MSB = 31;

  // imm16 sign-extended and shifted left by 2 (word offset -> byte offset).
  function automatic logic [31:0] branch_offset(input logic [31:0] inst);
    return {{14{inst[IMM16_MSB]}}, inst[IMM16_MSB:IMM16_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   pc_plus4 : address of the sequentially following instruction
//   inst     : instruction currently held for the decoder
//   m1       : 0 = jump, 1 = sequential/branch path
//   m5       : 1 = branch taken
//   next_pc  : selected next program counter
// Priority: jump (m1=0) over taken branch (m5=1) over sequential.
module if_next_pc
  import mips_if_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] inst,
  input  logic        m1,
  input  logic        m5,
  output logic [31:0] next_pc
);

  // Opcode bits are not needed for address generation.
  logic unused_opcode;
  assign unused_opcode = ^inst[31:JIDX_MSB+1];

  always_comb begin
    next_pc = pc_plus4;
    if (!m1) begin
      next_pc = {pc_plus4[REGION_MSB:REGION_LSB], inst[JIDX_MSB:JIDX_LSB], 2'b00};
    end else if (m5) begin
      next_pc = pc_plus4 + branch_offset(inst);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one instruction per commit
// over a req/ack memory handshake and holds it stable for the decoder.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_i             : hold current instruction (blocks commit)
//   m1_i, m5_i          : decoder jump / branch-taken selects (sampled in EXEC)
//   imem_req_o          : instruction memory read request
//   imem_addr_o         : fetch address (= pc_o)
//   imem_rdata_i        : instruction data, valid with imem_ack_i
//   imem_ack_i          : memory completes read this cycle
//   inst_o, inst_valid_o: held instruction and its valid flag
//   pc_o, pc_plus4_o    : current PC and PC + 4
// Optional build macro IF_PERF_CNT_EN adds:
//   perf_inst_cnt_o     : number of commits
//   perf_redirect_cnt_o : number of commits taking a jump or taken branch
module inst_fetch_unit
  import mips_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              m1_i,
  input  logic              m5_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  input  logic              imem_ack_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] pc_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       perf_inst_cnt_o,
  output logic [31:0]       perf_redirect_cnt_o,
`endif
  output logic [ADDR_W-1:0] pc_plus4_o
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;

  // Natural modulo-2^32 wrap: 32'hFFFF_FFFC + 4 = 0.
  assign pc_plus4 = pc_q + ADDR_W'(4);

  if_next_pc u_next_pc (
    .pc_plus4 (pc_plus4),
    .inst     (inst_o),
    .m1       (m1_i),
    .m5       (m5_i),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc_q         <= {RESET_PC[ADDR_W-1:2], 2'b00};
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      imem_req_o   <= 1'b0;
`ifdef IF_PERF_CNT_EN
      perf_inst_cnt_o     <= '0;
      perf_redirect_cnt_o <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state      <= FETCH;
          imem_req_o <= 1'b1;
        end
        FETCH: begin
          // No timeout: request and address stay stable until ack.
          if (imem_ack_i) begin
            inst_o       <= imem_rdata_i;
            inst_valid_o <= 1'b1;
            imem_req_o   <= 1'b0;
            state        <= EXEC;
          end
        end
        EXEC: begin
          if (!stall_i) begin
            pc_q         <= next_pc;
            inst_valid_o <= 1'b0;
            imem_req_o   <= 1'b1;
            state        <= FETCH;
`ifdef IF_PERF_CNT_EN
            perf_inst_cnt_o <= perf_inst_cnt_o + 32'd1;
            if (!m1_i || m5_i) begin
              perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
            end
`endif
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;
  assign pc_plus4_o  = pc_plus4;

endmodule
